// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//
// Streaming 3x3 neighbourhood generator. Takes a raster-order RGB pixel stream
// and emits one complete 3x3 RGB window per interior pixel. There is no border
// padding, so a frame yields (HEIGHT-2)*(WIDTH-2) windows.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    in_pixel holds a valid pixel
//   in_ready    block can accept a pixel this cycle (!out_valid || out_ready)
//   in_pixel    {R,G,B} pixel, 3*PW bits
//   in_sof      marks in_pixel as pixel (0,0) of a new frame
//   out_valid   out_window holds a valid window
//   out_ready   downstream accepts the window this cycle
//   out_window  element k = 3*r+c (r=0 top row, c=0 left column) at
//               bits [(k+1)*3*PW-1 : k*3*PW]
//   out_row     centre row of the window
//   out_col     centre column of the window
//   out_sof     window centre is (1,1)
//   out_eof     window centre is (HEIGHT-2, WIDTH-2)
module window_3x3_gen #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HEIGHT = 256,
    parameter int unsigned PW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*PW-1:0]   in_pixel,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [27*PW-1:0]  out_window,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              out_sof,
    output logic              out_eof
);

    localparam int unsigned PixW    = 3 * PW;
    localparam int unsigned AW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [15:0] ColLast = 16'(WIDTH - 1);
    localparam logic [15:0] RowLast = 16'(HEIGHT - 1);

    // Position counters
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2 (not reset)
    logic [PixW-1:0] lb0_q [WIDTH];
    logic [PixW-1:0] lb1_q [WIDTH];

    // Window shift register, indexed 3*row+col like out_window
    logic [PixW-1:0] win_q [9];
    logic [PixW-1:0] win_d [9];

    // Output registers
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_row_q, out_row_d;
    logic [15:0] out_col_q, out_col_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eof_q, out_eof_d;

    // Per-accept decode
    logic            accept;
    logic            produce;
    logic [15:0]     cur_col;
    logic [15:0]     cur_row;
    logic [AW-1:0]   lb_idx;
    logic [PixW-1:0] col_top;
    logic [PixW-1:0] col_mid;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // in_sof forces the accepted pixel to (0,0) whatever the counters say
    assign cur_col = in_sof ? 16'd0 : col_q;
    assign cur_row = in_sof ? 16'd0 : row_q;
    assign lb_idx  = cur_col[AW-1:0];
    assign col_top = lb1_q[lb_idx];
    assign col_mid = lb0_q[lb_idx];

    // Columns 0 and 1 of a row never produce a window, so the stale columns
    // left in the shift register from the previous row are never emitted.
    assign produce = accept && (cur_row >= 16'd2) && (cur_col >= 16'd2);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == ColLast) begin
                col_d = 16'd0;
                row_d = (cur_row == RowLast) ? 16'd0 : cur_row + 16'd1;
            end else begin
                col_d = cur_col + 16'd1;
                row_d = cur_row;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            win_d[k] = win_q[k];
        end
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2] = col_top;
            win_d[5] = col_mid;
            win_d[8] = in_pixel;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        if (produce) begin
            out_valid_d = 1'b1;
            out_row_d   = cur_row - 16'd1;
            out_col_d   = cur_col - 16'd1;
            out_sof_d   = (cur_row == 16'd2) && (cur_col == 16'd2);
            out_eof_d   = (cur_row == RowLast) && (cur_col == ColLast);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= 16'd0;
            row_q       <= 16'd0;
            out_valid_q <= 1'b0;
            out_row_q   <= 16'd0;
            out_col_q   <= 16'd0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[lb_idx] <= col_mid;
            lb0_q[lb_idx] <= in_pixel;
        end
    end

    // The window register only moves on accept, which cannot happen while a
    // window is stalled, so it doubles as the output window register.
    for (genvar k = 0; k < 9; k++) begin : g_out_win
        assign out_window[k*PixW +: PixW] = win_q[k];
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid;
    logic           in_ready;
    logic [23:0]    in_pixel;
    logic           in_sof;
    logic           out_valid;
    logic           out_ready;
    logic [215:0]   out_window;
    logic [15:0]    out_row;
    logic [15:0]    out_col;
    logic           out_sof;
    logic           out_eof;

    int checks   = 0;
    int failures = 0;

    // Record layout: {window[215:0], row[15:0], col[15:0], sof, eof}
    logic [249:0] got_q[$];
    bit           stall_prev = 1'b0;
    logic [215:0] held_win;
    bit           rand_ready = 1'b0;

    always #5 clk = ~clk;

    window_3x3_gen #(
        .WIDTH  (W),
        .HEIGHT (H),
        .PW     (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_sof    (out_sof),
        .out_eof    (out_eof)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected window centred on (r,c); every channel carries row*16+col
    function automatic logic [215:0] exp_win(input int r, input int c);
        logic [215:0] w;
        logic [7:0]   p;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            p = 8'(((r - 1 + k / 3) * 16) + (c - 1 + k % 3));
            w[k*24 +: 24] = {p, p, p};
        end
        return w;
    endfunction

    // Output monitor: log transfers, and flag any change of a stalled window
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("hold", out_window, held_win);
                if (out_valid && out_ready)
                    got_q.push_back({out_window, out_row, out_col, out_sof, out_eof});
                stall_prev = out_valid && !out_ready;
                held_win   = out_window;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Send n pixels of the W x H test frame; in_sof on frame index 0 if sof_en
    task automatic send(input int n, input bit sof_en, input int pct);
        for (int i = 0; i < n; i++) begin
            int         idx;
            int         guard;
            bit         acc;
            logic [7:0] p;
            idx   = i % (W * H);
            p     = 8'((idx / W) * 16 + (idx % W));
            guard = 0;
            acc   = 1'b0;
            while (!acc) begin
                in_valid = (pct >= 100) || (int'($urandom_range(0, 99)) < pct);
                in_pixel = {p, p, p};
                in_sof   = sof_en && (idx == 0);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 300) begin
                    check("send_timeout", 0, 1);
                    in_valid = 1'b0;
                    in_sof   = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify(input int nframes);
        check("count", 256'(got_q.size()), 256'(6 * nframes));
        for (int i = 0; i < got_q.size() && i < 6 * nframes; i++) begin
            int f;
            int r;
            int c;
            f = i % 6;
            r = 1 + f / 3;
            c = 1 + f % 3;
            check("window", {6'b0, got_q[i]},
                  {6'b0, exp_win(r, c), 16'(r), 16'(c), (r == 1 && c == 1), (r == 2 && c == 3)});
        end
    endtask

    initial begin
        logic [215:0] w;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {out_valid, out_window, out_row, out_col, out_sof, out_eof}, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean frame, free-running
        got_q.delete();
        send(20, 1'b1, 100);
        drain();
        verify(1);
        if (got_q.size() >= 6) begin
            w = got_q[0][249:34];
            check("first_k0", w[23:0], 24'h000000);
            check("first_k4", w[119:96], 24'h111111);
            check("first_k8", w[215:192], 24'h222222);
            check("first_sof", got_q[0][1], 1);
            w = got_q[5][249:34];
            check("last_k8", w[215:192], 24'h343434);
            check("last_eof", got_q[5][0], 1);
        end

        // Downstream stall on the first window
        got_q.delete();
        out_ready = 1'b0;
        fork
            send(20, 1'b1, 100);
            begin
                for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
                check("stall_valid", out_valid, 1);
                repeat (8) begin
                    @(negedge clk);
                    check("stall_ready", in_ready, 0);
                    check("stall_pos", {out_row, out_col}, {16'd1, 16'd1});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        verify(1);

        // Two back-to-back frames
        got_q.delete();
        send(40, 1'b1, 100);
        drain();
        verify(2);
        if (got_q.size() >= 7) begin
            w = got_q[6][249:34];
            check("f2_k4", w[119:96], 24'h111111);
            check("f2_sof", got_q[6][1], 1);
        end

        // in_sof at (2,1) abandons the frame
        got_q.delete();
        send(11, 1'b1, 100);
        send(20, 1'b1, 100);
        drain();
        verify(1);

        // Reset with a window pending
        got_q.delete();
        out_ready = 1'b0;
        send(13, 1'b1, 100);
        check("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        send(20, 1'b0, 100);
        drain();
        verify(1);

        // Random in_valid / out_ready
        got_q.delete();
        rand_ready = 1'b1;
        send(20, 1'b1, 50);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        drain();
        verify(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the blur kernel stage.
- Accepts a raster-order RGB pixel stream, top row first, left to right.
- Buffers two previous image lines and emits one complete 3x3 RGB window per interior pixel.
- The blur stage consumes each window and averages it per channel.

Parameters:
- WIDTH, 256, pixels per image row (>=3)
- HEIGHT, 256, rows per image (>=3)
- PW, 8, bits per colour channel; pixel word is 3*PW (R high, G mid, B low)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_pixel holds a valid pixel
- in_ready  output  1  block can accept a pixel this cycle
- in_pixel  input  3*PW  {R,G,B} pixel
- in_sof  input  1  qualifies in_pixel as the first pixel of a frame
- out_valid  output  1  out_window holds a valid window
- out_ready  input  1  downstream accepts the window this cycle
- out_window  output  27*PW  element k = 3*r+c (r = row 0 top, c = col 0 left) at bits [(k+1)*3*PW-1 : k*3*PW]
- out_row  output  16  centre row of the window
- out_col  output  16  centre column of the window
- out_sof  output  1  window centre is (1,1)
- out_eof  output  1  window centre is (HEIGHT-2, WIDTH-2)

Behaviour:
- Reset:
  - out_valid, out_window, out_row, out_col, out_sof and out_eof are all 0.
  - Column and row counters are 0.
  - Line buffer contents are don't-care and are not reset.
- Handshakes:
  - Input accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). Accepting a pixel and transferring a window in the same cycle is legal.
- Position counters (col 0..WIDTH-1, row 0..HEIGHT-1):
  - On accept with in_sof=1, the pixel is at (0,0) regardless of counter state.
  - Otherwise the pixel is at the current counter values.
  - After accept, col increments.
  - At col=WIDTH-1, col wraps to 0 and row increments.
  - At (HEIGHT-1, WIDTH-1), both counters wrap to 0.
- Line buffers: two arrays of WIDTH x 3*PW registers, lb0 (row r-1) and lb1 (row r-2), with combinational read by col.
  - On accept at (r,c): new column = {lb1[c], lb0[c], in_pixel} (top to bottom).
  - Then lb1[c] <= lb0[c] and lb0[c] <= in_pixel.
- Window shift register: 3 columns of 3 pixels. On accept, shift left by one column and insert the new column as column 2.
- Output generation:
  - Condition: accept at (r,c) with r>=2 and c>=2.
  - Next cycle: out_valid=1, out_window = shifted window, out_row=r-1, out_col=c-1.
  - Same cycle: out_sof=(r==2 && c==2), out_eof=(r==HEIGHT-1 && c==WIDTH-1).
- Latency: exactly 1 cycle from accept to out_valid.
- No output for accepts in rows 0-1 or cols 0-1. The stale columns that cross a row boundary are never emitted.
- Frame output count: (HEIGHT-2)*(WIDTH-2) windows, no border padding. The downstream stage owns border policy.
- Output registers:
  - When out_valid && !out_ready, all out_* signals hold stable.
  - When out_valid && out_ready and no new window is produced this cycle, out_valid clears next cycle.
  - When a transfer and a new window occur in the same cycle, out_valid stays 1 and the new window loads.
- Mid-frame in_sof: the current frame is abandoned and the counters restart as above. A partial output window may still be pending; it completes its handshake normally.
- Reset mid-operation clears any pending output immediately. The next accepted pixel is (0,0).
- in_pixel and in_sof are ignored when not accepted.

Test Plan:
- WIDTH=5, HEIGHT=4; per-channel value p=row*16+col, out_ready=1, continuous in_valid; first pixel with in_sof -> exactly 6 windows.
  - First window: centre (1,1), elements k0=0x00, k4=0x11, k8=0x22 in all channels, out_sof=1.
  - Last window: centre (2,3), k8=0x34, out_eof=1.
- Same frame, out_ready held 0 after the first window -> in_ready=0, out_window stays at centre (1,1). Releasing out_ready resumes with no lost or duplicated window (6 total).
- Two back-to-back frames with no gap -> 12 windows. Second frame's first window again has k4=0x11 and out_sof=1; line data from frame 1 never appears in a window.
- in_sof asserted at (2,1) of frame 1 -> the counters restart. Exactly 6 windows follow, all matching a clean frame, with out_sof on the first.
- rst pulsed while out_valid=1 -> out_valid=0 asynchronously. The next frame produces the correct 6 windows.
- Random in_valid/out_ready toggling (~50%) -> window sequence identical to scenario 1, and out_window never changes while out_valid && !out_ready.
